// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
// FSM state encoding and the CeilLog2 helper used to size counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Smallest n such that 2**n >= value (0 for value <= 1).
  function automatic int CeilLog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, flag-clear strobe and received-word outputs of uart_rx.
// The slave modport is the receiver side; master is the pin/host side.
// Optional macro: UART_RX_PARITY_EN adds the parity_err flag.
interface uart_rx_if #(
  parameter int Nbit = 8
);
  logic            SerialDataIn;
  logic            clr_rx_flag;
  logic [Nbit-1:0] DataRx;
  logic            rx_flag;
  logic            frame_err;
  logic            overrun_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport slave (
    input  SerialDataIn, clr_rx_flag,
    output DataRx, rx_flag, frame_err, overrun_err, parity_err
  );

  modport master (
    output SerialDataIn, clr_rx_flag,
    input  DataRx, rx_flag, frame_err, overrun_err, parity_err
  );
`else
  modport slave (
    input  SerialDataIn, clr_rx_flag,
    output DataRx, rx_flag, frame_err, overrun_err
  );

  modport master (
    output SerialDataIn, clr_rx_flag,
    input  DataRx, rx_flag, frame_err, overrun_err
  );
`endif
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so an idle (high) line is not mistaken for a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (by default) UART receiver with mid-bit sampling and sticky flags.
// Optional macro: UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and the sticky parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Nbit          = 8,
  parameter int baudrate      = 5,
  parameter int clk_freq      = 50,
  parameter int bit_time      = (clk_freq / baudrate) - 1,
  parameter int half_time     = bit_time / 2,
  parameter int baud_cnt_bits = CeilLog2(bit_time) + 1
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int BN_BITS = (Nbit > 1) ? CeilLog2(Nbit) : 1;

  localparam logic [baud_cnt_bits-1:0] BIT_LAST  = baud_cnt_bits'(bit_time);
  localparam logic [baud_cnt_bits-1:0] HALF_LAST = baud_cnt_bits'(half_time);
  localparam logic [baud_cnt_bits-1:0] BAUD_ONE  = baud_cnt_bits'(1);
  localparam logic [BN_BITS-1:0]       BIT_NUM_LAST = BN_BITS'(Nbit - 1);
  localparam logic [BN_BITS-1:0]       BIT_NUM_ONE  = BN_BITS'(1);

  logic rx_s;

  uart_state_t              state_reg, state_next;
  logic [baud_cnt_bits-1:0] baud_count_reg, baud_count_next;
  logic [BN_BITS-1:0]       bit_number_reg, bit_number_next;
  logic [Nbit-1:0]          buffer_reg, buffer_next;
  logic [Nbit-1:0]          data_rx_reg, data_rx_next;
  logic                     rx_flag_reg, rx_flag_next;
  logic                     frame_err_reg, frame_err_next;
  logic                     overrun_err_reg, overrun_err_next;
  logic                     sample_bit;
`ifdef UART_RX_PARITY_EN
  logic                     parity_err_reg, parity_err_next;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.SerialDataIn),
    .q     (rx_s)
  );

  // Per-bit write enable: only the bit addressed by bit_number captures rx_s.
  genvar gi;
  generate
    for (gi = 0; gi < Nbit; gi++) begin : g_buffer
      assign buffer_next[gi] = (sample_bit && (bit_number_reg == BN_BITS'(gi)))
                               ? rx_s : buffer_reg[gi];
    end
  endgenerate

  // State, counters, shift buffer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      baud_count_reg  <= '0;
      bit_number_reg  <= '0;
      buffer_reg      <= '0;
      data_rx_reg     <= '0;
      rx_flag_reg     <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg  <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      baud_count_reg  <= baud_count_next;
      bit_number_reg  <= bit_number_next;
      buffer_reg      <= buffer_next;
      data_rx_reg     <= data_rx_next;
      rx_flag_reg     <= rx_flag_next;
      frame_err_reg   <= frame_err_next;
      overrun_err_reg <= overrun_err_next;
`ifdef UART_RX_PARITY_EN
      parity_err_reg  <= parity_err_next;
`endif
    end
  end

  // Next-state logic; the flag clear is applied first so a same-cycle set wins.
  always_comb begin
    state_next       = state_reg;
    baud_count_next  = baud_count_reg;
    bit_number_next  = bit_number_reg;
    data_rx_next     = data_rx_reg;
    rx_flag_next     = rx_flag_reg;
    frame_err_next   = frame_err_reg;
    overrun_err_next = overrun_err_reg;
    sample_bit       = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_next  = parity_err_reg;
`endif

    if (!bus.clr_rx_flag) begin
      rx_flag_next     = 1'b0;
      frame_err_next   = 1'b0;
      overrun_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_next  = 1'b0;
`endif
    end

    case (state_reg)
      IDLE: begin
        baud_count_next = '0;
        bit_number_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (baud_count_reg == HALF_LAST) begin
          baud_count_next = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_next = rx_s ? IDLE : DATA;
        end else begin
          baud_count_next = baud_count_reg + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_count_reg == BIT_LAST) begin
          baud_count_next = '0;
          sample_bit      = 1'b1;
          if (bit_number_reg == BIT_NUM_LAST) begin
            bit_number_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_number_next = bit_number_reg + BIT_NUM_ONE;
          end
        end else begin
          baud_count_next = baud_count_reg + BAUD_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_count_reg == BIT_LAST) begin
          baud_count_next = '0;
          state_next      = STOP;
          if (rx_s != ^buffer_reg) begin
            parity_err_next = 1'b1;
          end
        end else begin
          baud_count_next = baud_count_reg + BAUD_ONE;
        end
      end
`endif

      STOP: begin
        if (baud_count_reg == BIT_LAST) begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
          baud_count_next = '0;
          state_next      = IDLE;
          if (rx_s) begin
            data_rx_next = buffer_reg;
            rx_flag_next = 1'b1;
            if (rx_flag_reg) begin
              overrun_err_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          baud_count_next = baud_count_reg + BAUD_ONE;
        end
      end

      default: begin
        state_next      = IDLE;
        baud_count_next = '0;
        bit_number_next = '0;
      end
    endcase
  end

  assign bus.DataRx      = data_rx_reg;
  assign bus.rx_flag     = rx_flag_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.overrun_err = overrun_err_reg;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parity_err_reg;
`endif

endmodule
